if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction word presented when no valid instruction is held (addi x0,x0,0).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_req  output  1  one-cycle instruction-memory read request.
REQ-006 mem_addr  output  32  word-aligned read address, valid while mem_req=1.
REQ-007 mem_rvalid  input  1  read data valid (one-cycle pulse, latency >=1 cycle after mem_req).
REQ-008 mem_rdata  input  32  instruction word, valid with mem_rvalid.
REQ-009 br_taken  input  1  redirect pulse from execute stage.
REQ-010 br_target  input  32  redirect address, valid with br_taken.
REQ-011 id_stall  input  1  decoder cannot accept the held instruction this cycle.
REQ-012 inst  output  32  instruction word to the decoder (decoder's inst input).
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-015 addr_misalign  output  1  one-cycle pulse: br_target[1:0] was nonzero.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, WAIT, VALID plus internal pc[31:0] and discard flag.
REQ-017 mem_req SHALL equal (state==FETCH), combinationally; mem_addr SHALL equal pc at all times.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-019 FETCH SHALL last exactly one cycle and go to WAIT; at most one request is outstanding at any time.
REQ-020 WAIT with mem_rvalid=1, discard=0, br_taken=0: inst<=mem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to VALID.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 WAIT with mem_rvalid=0 SHALL hold all outputs and state.
REQ-023 VALID SHALL hold inst, inst_pc, inst_valid=1 while id_stall=1.
REQ-024 VALID with id_stall=0: inst_valid<=0, inst<=NOP_INST, go to FETCH (instruction consumed in that cycle).
REQ-025 id_stall SHALL be ignored in all states except VALID.
REQ-026 br_taken SHALL have priority over every other event; on br_taken: pc<={br_target[31:2],2'b00}, inst_valid<=0, inst<=NOP_INST.
REQ-027 br_taken in IDLE or VALID: next state FETCH.
REQ-028 br_taken in FETCH: next state WAIT with discard<=1 (request already issued).
REQ-029 br_taken in WAIT with mem_rvalid=0: stay WAIT, discard<=1.
REQ-030 br_taken in WAIT with mem_rvalid=1: response dropped, discard<=0, next state FETCH.
REQ-031 WAIT with mem_rvalid=1, discard=1, br_taken=0: response dropped, pc unchanged, discard<=0, next state FETCH.
REQ-032 mem_rvalid outside WAIT SHALL be ignored (no output or pc change).
REQ-033 addr_misalign SHALL be registered, =1 for exactly the cycle after a br_taken with br_target[1:0]!=0, else 0.
REQ-034 inst_pc SHALL change only on REQ-020 loads.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, discard=0, inst=NOP_INST, inst_pc=0, inst_valid=0, addr_misalign=0, hence mem_req=0.
REQ-036 Reset mid-WAIT SHALL abandon the request; a late mem_rvalid arriving before the post-reset FETCH SHALL be ignored per REQ-032.

Verification
REQ-037 Reset release, memory latency 2, rdata 32'h0010_0093, id_stall=0 -> mem_req at cycle 2 addr 0, inst_valid=1 inst=32'h0010_0093 inst_pc=0 for one cycle, next mem_addr=4.
REQ-038 id_stall=1 for 3 cycles in VALID -> inst/inst_pc/inst_valid stable 3 cycles, no mem_req; fetch resumes cycle after stall drops.
REQ-039 br_taken target 32'h0000_0100 while WAIT, rvalid arrives next cycle -> response dropped, inst_valid stays 0, next mem_req addr 32'h100.
REQ-040 br_taken same cycle as mem_rvalid in WAIT -> no inst_valid, next mem_req addr = target.
REQ-041 br_target 32'h0000_0203 -> addr_misalign pulse one cycle, next mem_addr 32'h0000_0200.
REQ-042 RESET_PC=32'hFFFF_FFFC, one fetch -> inst_pc=32'hFFFF_FFFC, next mem_addr=32'h0000_0000.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/if_fetch.sv
// Single-outstanding instruction fetch stage: issues one read at a time, holds the
// returned word for the decoder, and redirects on branches (stale responses are dropped).
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_if.master  mem,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        addr_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              discard_q, discard_d;
  logic              misalign_q, misalign_d;

  assign mem.mem_req  = (state_q == S_FETCH);
  assign mem.mem_addr = pc_q;

  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_valid    = inst_valid_q;
  assign addr_misalign = misalign_q;

  // Next-state: a redirect overrides everything; otherwise walk the fetch sequence.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    discard_d    = discard_q;
    misalign_d   = br_taken && (br_target[1:0] != 2'b00);

    if (br_taken) begin
      pc_d         = {br_target[XLEN-1:2], 2'b00};
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      case (state_q)
        S_FETCH: begin
          // The request already left, so its response must be thrown away.
          state_d   = S_WAIT;
          discard_d = 1'b1;
        end
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            state_d   = S_FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            discard_d = 1'b0;
            if (discard_q) begin
              state_d = S_FETCH;
            end else begin
              inst_d       = mem.mem_rdata;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + XLEN'(4);
              state_d      = S_VALID;
            end
          end
        end
        S_VALID: begin
          if (!id_stall) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      discard_q    <= discard_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, reset corner cases, a wrap-around
// instance, and randomized traffic against a transaction-level model.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  if_fetch_if mem_bus();
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        addr_misalign;

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_bus.master),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .id_stall      (id_stall),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .addr_misalign (addr_misalign)
  );

  // Second instance starting at the top of the address space.
  if_fetch_if mem2();
  logic        br2;
  logic [31:0] tgt2;
  logic        stall2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic        inst_valid2;
  logic        mis2;

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem2.master),
    .br_taken      (br2),
    .br_target     (tgt2),
    .id_stall      (stall2),
    .inst          (inst2),
    .inst_pc       (inst_pc2),
    .inst_valid    (inst_valid2),
    .addr_misalign (mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_inst,
                         input logic [31:0] e_ipc, input logic e_mis);
    chk({tag, ".mem_req"},       32'(mem_bus.mem_req), 32'(e_req));
    chk({tag, ".mem_addr"},      mem_bus.mem_addr,     e_addr);
    chk({tag, ".inst_valid"},    32'(inst_valid),      32'(e_valid));
    chk({tag, ".inst"},          inst,                 e_inst);
    chk({tag, ".inst_pc"},       inst_pc,              e_ipc);
    chk({tag, ".addr_misalign"}, 32'(addr_misalign),   32'(e_mis));
  endtask

  // Transaction-level model: what is in flight, what is held, where we fetch next.
  logic [31:0] m_pc, m_inst, m_inst_pc;
  logic        m_valid, m_mis;
  logic        m_after_reset, m_issue, m_in_flight, m_stale, m_holding;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_inst = NOP; m_inst_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    m_after_reset = 1'b1; m_issue = 1'b0; m_in_flight = 1'b0; m_stale = 1'b0;
    m_holding = 1'b0;
  endtask

  task automatic model_step(input logic br, input logic [31:0] tgt, input logic stall,
                            input logic rv, input logic [31:0] rd);
    logic issue_next;
    issue_next = 1'b0;
    m_mis = br && (tgt % 4 != 0);
    if (br) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_inst = NOP;
      if (m_issue) begin
        m_in_flight = 1'b1; m_stale = 1'b1;
      end else if (m_in_flight) begin
        if (rv) begin m_in_flight = 1'b0; m_stale = 1'b0; issue_next = 1'b1; end
        else m_stale = 1'b1;
      end else begin
        m_holding = 1'b0; m_after_reset = 1'b0; issue_next = 1'b1;
      end
    end else if (m_after_reset) begin
      m_after_reset = 1'b0; issue_next = 1'b1;
    end else if (m_issue) begin
      m_in_flight = 1'b1;
    end else if (m_in_flight && rv) begin
      m_in_flight = 1'b0;
      if (m_stale) begin
        m_stale = 1'b0; issue_next = 1'b1;
      end else begin
        m_inst = rd; m_inst_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_holding = 1'b1;
      end
    end else if (m_holding && !stall) begin
      m_holding = 1'b0; m_valid = 1'b0; m_inst = NOP; issue_next = 1'b1;
    end
    m_issue = issue_next;
  endtask

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vec[19];

  initial begin
    logic saw_req;
    bit   found;

    // Row: inputs applied after checking the expected outputs at that cycle.
    vec[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,   1'b0, NOP,          32'h0,   1'b0};
    vec[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0,   1'b0, NOP,          32'h0,   1'b0};
    vec[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b0, NOP,          32'h0,   1'b0};
    vec[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'h0,   1'b0, NOP,          32'h0,   1'b0};
    vec[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h4,   1'b1, 32'h0010_0093, 32'h0,  1'b0};
    vec[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h4,   1'b1, 32'h0010_0093, 32'h0,  1'b0};
    vec[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h4,   1'b1, 32'h0010_0093, 32'h0,  1'b0};
    vec[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h4,   1'b1, 32'h0010_0093, 32'h0,  1'b0};
    vec[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h4,   1'b0, NOP,          32'h0,   1'b0};
    vec[9]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,   1'b0, NOP,          32'h0,   1'b0};
    vec[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100, 1'b0, NOP,          32'h0,   1'b0};
    vec[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 1'b0, NOP,          32'h0,   1'b0};
    vec[12] = '{1'b1, 32'h203, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h100, 1'b0, NOP,          32'h0,   1'b0};
    vec[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h200, 1'b0, NOP,          32'h0,   1'b1};
    vec[14] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0050_0113, 1'b0, 32'h200, 1'b0, NOP,          32'h0,   1'b0};
    vec[15] = '{1'b1, 32'h40,  1'b1, 1'b0, 32'h0,         1'b0, 32'h204, 1'b1, 32'h0050_0113, 32'h200, 1'b0};
    vec[16] = '{1'b1, 32'h80,  1'b0, 1'b0, 32'h0,         1'b1, 32'h40,  1'b0, NOP,          32'h200, 1'b0};
    vec[17] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h80,  1'b0, NOP,          32'h200, 1'b0};
    vec[18] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h80,  1'b0, NOP,          32'h200, 1'b0};

    rst_n = 1'b0;
    br_taken = 1'b0; br_target = 32'h0; id_stall = 1'b0;
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    br2 = 1'b0; tgt2 = 32'h0; stall2 = 1'b0;
    mem2.mem_rvalid = 1'b0; mem2.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // PC wrap: one fetch from 0xFFFF_FFFC, next fetch address wraps to 0.
    rst_n = 1'b1;
    saw_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (inst_valid2) begin
        found = 1'b1;
        chk("wrap.inst_pc", inst_pc2, 32'hFFFF_FFFC);
        chk("wrap.inst", inst2, 32'h0000_0093);
        chk("wrap.next_addr", mem2.mem_addr, 32'h0000_0000);
        chk("wrap.misalign", 32'(mis2), 32'h0);
      end else begin
        mem2.mem_rvalid = saw_req;
        mem2.mem_rdata  = 32'h0000_0093;
        saw_req = mem2.mem_req;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wrap.timeout: got no inst_valid expected one within 20 cycles");
    end
    mem2.mem_rvalid = 1'b0;

    // Directed vector table from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      chk_all($sformatf("vec%0d", i), vec[i].e_req, vec[i].e_addr, vec[i].e_valid,
              vec[i].e_inst, vec[i].e_ipc, vec[i].e_mis);
      br_taken = vec[i].br; br_target = vec[i].tgt; id_stall = vec[i].stall;
      mem_bus.mem_rvalid = vec[i].rv; mem_bus.mem_rdata = vec[i].rd;
      @(negedge clk);
    end

    // Reset while a request is outstanding; a late response in IDLE is ignored.
    chk_all("midwait.pre", 1'b0, 32'h80, 1'b0, NOP, 32'h200, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("midwait.rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_all("midwait.fetch", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
    mem_bus.mem_rvalid = 1'b0;

    // Randomized traffic against the model, with occasional resets.
    rst_n = 1'b0;
    model_reset(32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chk_all("rand", m_issue, m_pc, m_valid, m_inst, m_inst_pc, m_mis);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset(32'h0);
      end else begin
        rst_n = 1'b1;
        br_taken  = ($urandom_range(0, 9) == 0);
        br_target = $urandom;
        if ($urandom_range(0, 3) == 0) br_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else if ($urandom_range(0, 1) == 0) br_target = br_target & 32'hFFFF_FFFC;
        id_stall  = ($urandom_range(0, 1) == 1);
        mem_bus.mem_rvalid = ($urandom_range(0, 4) < 2);
        mem_bus.mem_rdata  = $urandom;
        model_step(br_taken, br_target, id_stall, mem_bus.mem_rvalid, mem_bus.mem_rdata);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
